// File: rtl/timer_seq_pkg.sv
// Shared types and encodings for the timer sequencer: FSM states, table field codes, timer register map.
package timer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PER,
    ST_WR_DUTY,
    ST_WR_REP,
    ST_START,
    ST_WAIT
  } state_e;

  localparam logic [1:0] FLD_PERIOD = 2'd0;
  localparam logic [1:0] FLD_DUTY   = 2'd1;
  localparam logic [1:0] FLD_REPEAT = 2'd2;

  localparam logic [1:0] TMR_ADDR_PERIOD = 2'd0;
  localparam logic [1:0] TMR_ADDR_DUTY   = 2'd1;
  localparam logic [1:0] TMR_ADDR_REPEAT = 2'd2;

  // Table field read in a given state; non-write states read the period (used for the skip test)
  function automatic logic [1:0] state_field(state_e s);
    case (s)
      ST_WR_DUTY: return FLD_DUTY;
      ST_WR_REP:  return FLD_REPEAT;
      default:    return FLD_PERIOD;
    endcase
  endfunction

  function automatic logic [1:0] state_addr(state_e s);
    case (s)
      ST_WR_DUTY: return TMR_ADDR_DUTY;
      ST_WR_REP:  return TMR_ADDR_REPEAT;
      default:    return TMR_ADDR_PERIOD;
    endcase
  endfunction

endpackage

// File: rtl/timer_seq_table.sv
// Profile table: N_ENTRY x {period, duty, repeat}; one synchronous write port, one combinational read port.
// Field code 3 is reserved: writes are dropped and reads return 0.
module timer_seq_table
  import timer_seq_pkg::*;
#(
  parameter int DW      = 16,
  parameter int N_ENTRY = 4,
  parameter int IDX_W   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [1:0]       wfld_i,
  input  logic [DW-1:0]    wdat_i,
  input  logic [IDX_W-1:0] ridx_i,
  input  logic [1:0]       rfld_i,
  output logic [DW-1:0]    rdat_o
);

  logic [DW-1:0] per_q  [N_ENTRY];
  logic [DW-1:0] duty_q [N_ENTRY];
  logic [DW-1:0] rep_q  [N_ENTRY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        per_q[i]  <= '0;
        duty_q[i] <= '0;
        rep_q[i]  <= '0;
      end
    end else if (we_i) begin
      case (wfld_i)
        FLD_PERIOD: per_q[widx_i]  <= wdat_i;
        FLD_DUTY:   duty_q[widx_i] <= wdat_i;
        FLD_REPEAT: rep_q[widx_i]  <= wdat_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdat_o = '0;
    case (rfld_i)
      FLD_PERIOD: rdat_o = per_q[ridx_i];
      FLD_DUTY:   rdat_o = duty_q[ridx_i];
      FLD_REPEAT: rdat_o = rep_q[ridx_i];
      default:    rdat_o = '0;
    endcase
  end

endmodule

// File: rtl/timer_sequencer.sv
// Walks the profile table: per entry writes period/duty/repeat to the timer, pulses start, waits for end.
// Outputs decode only registered state; TSEQ_TIMEOUT_EN adds a WAIT timeout that aborts with o_err.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int DW      = 16,
  parameter int N_ENTRY = 4,
  parameter int IDX_W   = 2
`ifdef TSEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_we,
  input  logic [IDX_W-1:0] i_cfg_idx,
  input  logic [1:0]       i_cfg_field,
  input  logic [DW-1:0]    i_cfg_wdata,
  input  logic [IDX_W-1:0] i_last_idx,
  input  logic             i_loop,
  input  logic             i_go,
  input  logic             i_stop,
  input  logic             i_timer_end,
  output logic             o_tmr_we,
  output logic [1:0]       o_tmr_addr,
  output logic [DW-1:0]    o_tmr_wdata,
  output logic             o_tmr_start,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_done,
  output logic             o_err
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] last_q;
  logic             loop_q;
  logic             done_q;

  logic [DW-1:0]    rd_dat;
  logic             skip;

  state_e           adv_state_d;
  logic [IDX_W-1:0] adv_idx_d;
  logic             adv_done_d;

`ifdef TSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  timer_seq_table #(
    .DW      (DW),
    .N_ENTRY (N_ENTRY),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .we_i   (i_cfg_we && (state_q == ST_IDLE)),
    .widx_i (i_cfg_idx),
    .wfld_i (i_cfg_field),
    .wdat_i (i_cfg_wdata),
    .ridx_i (idx_q),
    .rfld_i (state_field(state_q)),
    .rdat_o (rd_dat)
  );

  // A zero-period entry is treated as already ended: it advances from WR_PER without writing
  assign skip = (state_q == ST_WR_PER) && (rd_dat == '0);

  always_comb begin
    adv_state_d = ST_WR_PER;
    adv_idx_d   = '0;
    adv_done_d  = 1'b0;
    if (idx_q < last_q) begin
      adv_idx_d = idx_q + 1'b1;
    end else if (!loop_q) begin
      adv_state_d = ST_IDLE;
      adv_idx_d   = idx_q;
      adv_done_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TSEQ_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef TSEQ_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      if ((state_q != ST_IDLE) && i_stop) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_go && !i_stop) begin
              last_q  <= i_last_idx;
              loop_q  <= i_loop;
              idx_q   <= '0;
              state_q <= ST_WR_PER;
            end
          end
          ST_WR_PER: begin
            if (skip) begin
              state_q <= adv_state_d;
              idx_q   <= adv_idx_d;
              done_q  <= adv_done_d;
            end else begin
              state_q <= ST_WR_DUTY;
            end
          end
          ST_WR_DUTY: state_q <= ST_WR_REP;
          ST_WR_REP:  state_q <= ST_START;
          ST_START: begin
            state_q <= ST_WAIT;
`ifdef TSEQ_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
          ST_WAIT: begin
            if (i_timer_end) begin
              state_q <= adv_state_d;
              idx_q   <= adv_idx_d;
              done_q  <= adv_done_d;
            end
`ifdef TSEQ_TIMEOUT_EN
            else if (cnt_q == CNT_TERM) begin
              state_q <= ST_IDLE;
              err_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
`endif
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_tmr_we    = ((state_q == ST_WR_PER) && !skip) ||
                       (state_q == ST_WR_DUTY) || (state_q == ST_WR_REP);
  assign o_tmr_addr  = o_tmr_we ? state_addr(state_q) : 2'd0;
  assign o_tmr_wdata = o_tmr_we ? rd_dat : '0;
  assign o_tmr_start = (state_q == ST_START);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_idx       = idx_q;
  assign o_done      = done_q;
`ifdef TSEQ_TIMEOUT_EN
  assign o_err       = err_q;
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: event-queue reference model of the profile walk plus directed hazard cases.
module tb_timer_sequencer;

  localparam int DW      = 16;
  localparam int N_ENTRY = 4;
  localparam int IDX_W   = 2;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_cfg_we;
  logic [IDX_W-1:0] i_cfg_idx;
  logic [1:0]       i_cfg_field;
  logic [DW-1:0]    i_cfg_wdata;
  logic [IDX_W-1:0] i_last_idx;
  logic             i_loop;
  logic             i_go;
  logic             i_stop;
  logic             i_timer_end;
  logic             o_tmr_we;
  logic [1:0]       o_tmr_addr;
  logic [DW-1:0]    o_tmr_wdata;
  logic             o_tmr_start;
  logic             o_busy;
  logic [IDX_W-1:0] o_idx;
  logic             o_done;
  logic             o_err;

  always #5 clk = ~clk;

  timer_sequencer #(
    .DW      (DW),
    .N_ENTRY (N_ENTRY),
    .IDX_W   (IDX_W)
`ifdef TSEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (10)
`endif
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_idx   (i_cfg_idx),
    .i_cfg_field (i_cfg_field),
    .i_cfg_wdata (i_cfg_wdata),
    .i_last_idx  (i_last_idx),
    .i_loop      (i_loop),
    .i_go        (i_go),
    .i_stop      (i_stop),
    .i_timer_end (i_timer_end),
    .o_tmr_we    (o_tmr_we),
    .o_tmr_addr  (o_tmr_addr),
    .o_tmr_wdata (o_tmr_wdata),
    .o_tmr_start (o_tmr_start),
    .o_busy      (o_busy),
    .o_idx       (o_idx),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  // kind: 0 timer write, 1 start, 2 done, 3 err
  typedef struct {
    int kind;
    int addr;
    int data;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  int  mtbl [N_ENTRY][3];
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;

  function automatic ev_t mk(input int kind, input int addr, input int data, input int idx);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.idx  = idx;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Walk entries in order from 0, skipping period==0, wrapping if looping; stop after max_starts starts
  task automatic model_run(input int last, input bit loop, input int max_starts);
    int i;
    int n;
    i = 0;
    n = 0;
    for (int guard = 0; guard < 64; guard++) begin
      if (mtbl[i][0] != 0) begin
        for (int f = 0; f < 3; f++) exp_q.push_back(mk(0, f, mtbl[i][f], i));
        exp_q.push_back(mk(1, 0, 0, i));
        n++;
        if (n == max_starts) return;
      end
      if (i == last) begin
        if (!loop) begin
          exp_q.push_back(mk(2, 0, 0, 0));
          return;
        end
        i = 0;
      end else begin
        i++;
      end
    end
  endtask

  function automatic int n_active(input int last);
    int n;
    n = 0;
    for (int i = 0; i <= last; i++) if (mtbl[i][0] != 0) n++;
    return n;
  endfunction

  ev_t cmp_e;
  int  cmp_k;
  bit  cmp_bad;

  always @(negedge clk) begin
    if (mon_en && !i_rst && (o_tmr_we || o_tmr_start || o_done || o_err)) begin
      cmp_k = o_tmr_we ? 0 : (o_tmr_start ? 1 : (o_done ? 2 : 3));
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL event: got kind=%0d addr=%0d data=%0d idx=%0d, required no timer activity",
                 cmp_k, o_tmr_addr, o_tmr_wdata, o_idx);
      end else begin
        cmp_e = exp_q.pop_front();
        cmp_bad = (cmp_k != cmp_e.kind) || (o_tmr_we && o_tmr_start);
        if (cmp_k == 0 && (int'(o_tmr_addr) != cmp_e.addr || int'(o_tmr_wdata) != cmp_e.data ||
                           int'(o_idx) != cmp_e.idx)) cmp_bad = 1'b1;
        if (cmp_k == 1 && int'(o_idx) != cmp_e.idx) cmp_bad = 1'b1;
        if (cmp_k == 2 && o_busy) cmp_bad = 1'b1;
        if (cmp_bad) begin
          fails++;
          $display("FAIL event: got kind=%0d addr=%0d data=%0d idx=%0d busy=%0d, required kind=%0d addr=%0d data=%0d idx=%0d",
                   cmp_k, o_tmr_addr, o_tmr_wdata, o_idx, o_busy,
                   cmp_e.kind, cmp_e.addr, cmp_e.data, cmp_e.idx);
        end
      end
    end
  end

  task automatic cfg_write(input int idx, input int fld, input int data, input bit upd);
    i_cfg_we    = 1'b1;
    i_cfg_idx   = IDX_W'(idx);
    i_cfg_field = 2'(fld);
    i_cfg_wdata = DW'(data);
    @(negedge clk);
    i_cfg_we = 1'b0;
    if (upd && fld != 3) mtbl[idx][fld] = data;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (o_tmr_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_start", 0, 1);
  endtask

  task automatic wait_idle_and_drain(input string name);
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!o_busy) begin
        idle = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_idle"}, int'(idle), 1);
    @(negedge clk);
    @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Runs one sequence; ends the first nstarts-1 entries, and the last one too unless do_stop
  task automatic run_seq(input string name, input int last, input bit loop, input int nstarts,
                         input bit do_stop, input bit stop_end, input bit inject);
    bit ok;
    model_run(last, loop, do_stop ? nstarts : 1000);
    i_last_idx = IDX_W'(last);
    i_loop     = loop;
    i_go       = 1'b1;
    @(negedge clk);
    i_go       = 1'b0;
    i_last_idx = IDX_W'($urandom);
    i_loop     = 1'($urandom);
    for (int s = 0; s < nstarts; s++) begin
      wait_start(ok);
      if (!ok) break;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if (inject && s == 0) begin
        i_go        = 1'b1;
        i_cfg_we    = 1'b1;
        i_cfg_idx   = '0;
        i_cfg_field = 2'd0;
        i_cfg_wdata = 16'h7777;
        @(negedge clk);
        i_go     = 1'b0;
        i_cfg_we = 1'b0;
      end
      if (do_stop && s == nstarts - 1) begin
        i_stop      = 1'b1;
        i_timer_end = stop_end;
      end else begin
        i_timer_end = 1'b1;
      end
      @(negedge clk);
      i_stop      = 1'b0;
      i_timer_end = 1'b0;
    end
    wait_idle_and_drain(name);
  endtask

  bit ok;
  int cnt;
  bit err_seen;
  int last, na, nst;
  bit lp, dstop;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_field = '0; i_cfg_wdata = '0;
    i_last_idx = '0; i_loop = 1'b0; i_go = 1'b0; i_stop = 1'b0; i_timer_end = 1'b0;
    for (int i = 0; i < N_ENTRY; i++) for (int f = 0; f < 3; f++) mtbl[i][f] = 0;
    #1;
    check("rst_we", int'(o_tmr_we), 0);
    check("rst_start", int'(o_tmr_start), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_idx", int'(o_idx), 0);
    check("rst_wdata", int'(o_tmr_wdata), 0);
    @(negedge clk);
    @(negedge clk);
    i_rst  = 1'b0;
    mon_en = 1'b1;

    // Basic two-entry run with literal expectations
    cfg_write(0, 0, 20, 1); cfg_write(0, 1, 10, 1); cfg_write(0, 2, 2, 1);
    cfg_write(1, 0, 8, 1);  cfg_write(1, 1, 4, 1);  cfg_write(1, 2, 1, 1);
    model_run(1, 0, 1000);
    i_last_idx = 2'd1; i_loop = 1'b0; i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    check("t1_we0", int'(o_tmr_we), 1);
    check("t1_addr0", int'(o_tmr_addr), 0);
    check("t1_dat0", int'(o_tmr_wdata), 20);
    check("t1_busy", int'(o_busy), 1);
    @(negedge clk);
    check("t1_addr1", int'(o_tmr_addr), 1);
    check("t1_dat1", int'(o_tmr_wdata), 10);
    @(negedge clk);
    check("t1_addr2", int'(o_tmr_addr), 2);
    check("t1_dat2", int'(o_tmr_wdata), 2);
    @(negedge clk);
    check("t1_start", int'(o_tmr_start), 1);
    check("t1_start_we", int'(o_tmr_we), 0);
    @(negedge clk);
    i_timer_end = 1'b1;
    @(negedge clk);
    i_timer_end = 1'b0;
    check("t1_e1_dat0", int'(o_tmr_wdata), 8);
    check("t1_e1_idx", int'(o_idx), 1);
    wait_start(ok);
    @(negedge clk);
    i_timer_end = 1'b1;
    @(negedge clk);
    i_timer_end = 1'b0;
    check("t1_done", int'(o_done), 1);
    check("t1_done_busy", int'(o_busy), 0);
    @(negedge clk);
    check("t1_done_pulse", int'(o_done), 0);
    wait_idle_and_drain("t1");

    run_seq("loop", 1, 1'b1, 4, 1'b1, 1'b0, 1'b0);

    cfg_write(1, 0, 0, 1);
    cfg_write(2, 0, 6, 1); cfg_write(2, 1, 3, 1); cfg_write(2, 2, 1, 1);
    run_seq("skip", 2, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    run_seq("stop_end", 2, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    run_seq("busy_inject", 2, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    run_seq("after_inject", 2, 1'b0, 2, 1'b0, 1'b0, 1'b0);

    // go and stop together in IDLE
    i_go = 1'b1; i_stop = 1'b1;
    @(negedge clk);
    i_go = 1'b0; i_stop = 1'b0;
    check("go_stop_idle", int'(o_busy), 0);

    // Table write in the go cycle is seen by the sequence
    mtbl[0][1] = 99;
    model_run(0, 0, 1000);
    i_cfg_we = 1'b1; i_cfg_idx = '0; i_cfg_field = 2'd1; i_cfg_wdata = 16'd99;
    i_last_idx = '0; i_loop = 1'b0; i_go = 1'b1;
    @(negedge clk);
    i_cfg_we = 1'b0; i_go = 1'b0;
    wait_start(ok);
    @(negedge clk);
    i_timer_end = 1'b1;
    @(negedge clk);
    i_timer_end = 1'b0;
    wait_idle_and_drain("wr_go");

    // Reset in WR_DUTY
    model_run(2, 0, 1000);
    i_last_idx = 2'd2; i_loop = 1'b0; i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_tmr_we && o_tmr_addr == 2'd1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_find_duty", int'(ok), 1);
    #2 i_rst = 1'b1;
    #1;
    check("midrst_we", int'(o_tmr_we), 0);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_wdata", int'(o_tmr_wdata), 0);
    check("midrst_idx", int'(o_idx), 0);
    exp_q.delete();
    for (int i = 0; i < N_ENTRY; i++) for (int f = 0; f < 3; f++) mtbl[i][f] = 0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    run_seq("cleared", 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // WAIT with no timer end
    cfg_write(0, 0, 5, 1); cfg_write(0, 1, 2, 1); cfg_write(0, 2, 1, 1);
    model_run(0, 1'b0, 1);
`ifdef TSEQ_TIMEOUT_EN
    exp_q.push_back(mk(3, 0, 0, 0));
`endif
    i_last_idx = '0; i_loop = 1'b0; i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    wait_start(ok);
`ifdef TSEQ_TIMEOUT_EN
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (o_err) begin
        cnt = c;
        break;
      end
    end
    check("timeout_latency", cnt, 11);
    check("timeout_busy", int'(o_busy), 0);
    check("timeout_done", int'(o_done), 0);
`else
    err_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_err) err_seen = 1'b1;
    end
    check("notimeout_err", int'(err_seen), 0);
    check("notimeout_busy", int'(o_busy), 1);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    check("notimeout_stop", int'(o_busy), 0);
`endif
    wait_idle_and_drain("timeout");

    // Randomized sequences
    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < 6; w++) begin
        cfg_write($urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 65535), 1'b1);
      end
      last = $urandom_range(0, 3);
      lp   = 1'($urandom);
      if (lp) begin
        if (n_active(last) == 0) cfg_write(0, 0, $urandom_range(1, 1000), 1'b1);
        nst   = $urandom_range(1, 5);
        dstop = 1'b1;
      end else begin
        na    = n_active(last);
        dstop = (na > 0) && ($urandom_range(0, 2) == 0);
        nst   = dstop ? $urandom_range(1, na) : na;
      end
      run_seq("rand", last, lp, nst, dstop, 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
